// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide scheduler: opcodes, FSM states
// and default latencies.
package md_pkg;

  localparam int unsigned MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_LAT_DEF = 5;
  localparam int unsigned MD_DIV_LAT_DEF  = 10;

  function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// EX/ID-side bundle of the md scheduler: op issue, operands, stall and HI/LO view.
interface md_sched_if;

    logic [md_pkg::MD_OP_W-1:0] EX_md_op;
    logic                       EX_valid;
    logic [31:0]                EX_A;
    logic [31:0]                EX_B;
    logic                       ID_MD;
    logic                       md_stall;
    logic                       md_busy;
    logic [31:0]                md_rdata;
    logic [31:0]                HI;
    logic [31:0]                LO;

    modport master (
        output EX_md_op, EX_valid, EX_A, EX_B, ID_MD,
        input  md_stall, md_busy, md_rdata, HI, LO
    );

    modport slave (
        input  EX_md_op, EX_valid, EX_A, EX_B, ID_MD,
        output md_stall, md_busy, md_rdata, HI, LO
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath. Division works on magnitudes and
// re-applies signs, so the signed and unsigned forms share one divider.
module md_arith
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic               is_signed;
    logic [31:0]        a_mag, b_mag, b_div;
    logic [31:0]        q_mag, r_mag;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    assign is_signed = (op == MD_DIV);
    assign a_mag     = (is_signed && A[31]) ? (32'd0 - A) : A;
    assign b_mag     = (is_signed && B[31]) ? (32'd0 - B) : B;
    // Keep the divider defined on a zero divisor; the result is discarded anyway.
    assign b_div     = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag     = a_mag / b_div;
    assign r_mag     = a_mag % b_div;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = A[31] ? (32'd0 - r_mag) : r_mag;
                div0   = (B == 32'd0);
            end
            MD_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
                div0   = (B == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div sequencer owning HI/LO: accepts one op from EX, waits a
// fixed latency, then commits; requests an ID stall while the unit is busy.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_LAT = MD_MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = (MaxLat > 2) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_LAT - 1);
    localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_LAT - 1);

    md_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     hi_q, lo_q, pend_hi_q, pend_lo_q;
    logic            pend_div0_q;

    md_op_e      op;
    logic        start;
    logic        is_div;
    logic [31:0] res_hi, res_lo;
    logic        div0;

    assign op     = md_op_e'(bus.EX_md_op);
    assign is_div = (op == MD_DIV) || (op == MD_DIVU);
    // Gated by reset so busy/stall read low while the block is held in reset.
    assign start  = reset && bus.EX_valid && (state_q == MD_IDLE) && md_is_arith(op);

    md_arith u_arith (
        .op     (op),
        .A      (bus.EX_A),
        .B      (bus.EX_B),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_div0_q <= 1'b0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        state_q     <= MD_BUSY;
                        cnt_q       <= is_div ? DivCnt : MultCnt;
                        pend_hi_q   <= res_hi;
                        pend_lo_q   <= res_lo;
                        pend_div0_q <= div0;
                    end else if (bus.EX_valid && (op == MD_MTHI)) begin
                        hi_q <= bus.EX_A;
                    end else if (bus.EX_valid && (op == MD_MTLO)) begin
                        lo_q <= bus.EX_A;
                    end
                end
                MD_BUSY: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= MD_IDLE;
                        // A zero divisor leaves HI/LO as they were.
                        if (!pend_div0_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && (state_q == MD_BUSY) && bus.EX_valid && (op != MD_NONE)) begin
            $display("md_sched: md op %0d issued while busy, ignored", op);
        end
    end
`endif

    assign bus.md_busy  = (state_q == MD_BUSY) || start;
    assign bus.md_stall = bus.ID_MD && bus.md_busy;
    assign bus.md_rdata = (op == MD_MFHI) ? hi_q :
                          (op == MD_MFLO) ? lo_q : 32'd0;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

endmodule
